// File: rtl/freq_meter.sv
// Gated edge counter: counts sig_in rising edges over GATE_CYCLES clocks; PERIOD_MEAS_EN adds edge-to-edge period output.
// Latency: edge counted 3 clk after sig_in; freq_valid 1 clk after the terminal gate cycle.
// Backpressure: none, results are strobes that the consumer must take when they appear.
module freq_meter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int COUNT_W     = 27
) (
    input  logic               clk_50M,
    input  logic               rst_n,
    input  logic               sig_in,
    input  logic               enable,
    output logic [COUNT_W-1:0] freq_out,
    output logic               freq_valid,
    output logic               overflow,
    output logic               busy
`ifdef PERIOD_MEAS_EN
    ,
    output logic [31:0]        period_out,
    output logic               period_valid
`endif
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0]  GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [GATE_W-1:0]  GATE_ONE  = GATE_W'(1);
    localparam logic [COUNT_W-1:0] CNT_MAX   = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE   = COUNT_W'(1);

    typedef enum logic {IDLE, MEASURE} state_t;

    state_t state_q, state_d;

    logic               sync1, sync2, sync_dly;
    logic               edge_det;
    logic [GATE_W-1:0]  gate_cnt;
    logic [COUNT_W-1:0] edge_cnt;
    logic               sat;
    logic [COUNT_W-1:0] cnt_next;
    logic               sat_next;
    logic               cnt_clr, cnt_run, publish;

    // Synchronizer runs regardless of state so a level already high at enable is not an edge.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync_dly <= 1'b0;
        end else begin
            sync1    <= sig_in;
            sync2    <= sync1;
            sync_dly <= sync2;
        end
    end

    assign edge_det = sync2 & ~sync_dly;

    always_comb begin
        cnt_next = edge_cnt;
        sat_next = sat;
        if (edge_det) begin
            if (edge_cnt == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = edge_cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_run = 1'b0;
        publish = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = MEASURE;
                    cnt_clr = 1'b1;
                end
            end
            MEASURE: begin
                if (gate_cnt == GATE_LAST) begin
                    publish = 1'b1;
                    // Restarting in the same cycle keeps back-to-back gates gap-free.
                    if (enable) begin
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (!enable) begin
                    state_d = IDLE;
                end else begin
                    cnt_run = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (cnt_clr) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            sat      <= 1'b0;
        end else if (cnt_run) begin
            gate_cnt <= gate_cnt + GATE_ONE;
            edge_cnt <= cnt_next;
            sat      <= sat_next;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            freq_out   <= '0;
            overflow   <= 1'b0;
            freq_valid <= 1'b0;
        end else begin
            freq_valid <= publish;
            if (publish) begin
                freq_out <= cnt_next;
                overflow <= sat_next;
            end
        end
    end

    assign busy = (state_q == MEASURE);

`ifdef PERIOD_MEAS_EN
    logic [31:0] per_cnt;
    logic        per_seen;

    // First edge after reset only arms the counter; every later edge publishes.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt      <= '0;
            per_seen     <= 1'b0;
            period_out   <= '0;
            period_valid <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (edge_det) begin
                if (per_seen) begin
                    period_out   <= per_cnt;
                    period_valid <= 1'b1;
                end
                per_seen <= 1'b1;
                per_cnt  <= 32'd1;
            end else if (per_cnt != 32'hFFFF_FFFF) begin
                per_cnt <= per_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter: expected counts come from a timestamped list of applied sig_in edges.
module tb_freq_meter;
    localparam int GATE = 1000;
    localparam int CW   = 8;
    localparam int CMAX = 255;

    logic          clk_50M = 1'b0;
    logic          rst_n   = 1'b0;
    logic          sig_in  = 1'b0;
    logic          enable  = 1'b0;
    logic [CW-1:0] freq_out;
    logic          freq_valid;
    logic          overflow;
    logic          busy;
`ifdef PERIOD_MEAS_EN
    logic [31:0]   period_out;
    logic          period_valid;
`endif

    freq_meter #(.GATE_CYCLES(GATE), .COUNT_W(CW)) dut (
        .clk_50M    (clk_50M),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .enable     (enable),
        .freq_out   (freq_out),
        .freq_valid (freq_valid),
        .overflow   (overflow),
        .busy       (busy)
`ifdef PERIOD_MEAS_EN
        ,
        .period_out   (period_out),
        .period_valid (period_valid)
`endif
    );

    always #5 clk_50M = ~clk_50M;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int period = 0;
    int ph    = 0;
    int edge_q[$];
    int last_exp = 0;
    logic last_ovf = 1'b0;

    // Signal generator: square wave of 'period' clocks; logs the cycle of each rising edge.
    initial begin
        logic nxt;
        forever begin
            @(posedge clk_50M);
            cyc++;
            #1;
            if (period > 0) begin
                ph  = (ph + 1) % period;
                nxt = (ph < period / 2);
            end else begin
                nxt = 1'b0;
            end
            if (nxt && !sig_in) edge_q.push_back(cyc);
            sig_in = nxt;
        end
    end

    // An edge applied in cycle t is detected in cycle t+2; count those detected in [lo,hi].
    function automatic int model(input int lo, input int hi);
        int n = 0;
        foreach (edge_q[i]) if (edge_q[i] + 2 >= lo && edge_q[i] + 2 <= hi) n++;
        return n;
    endfunction

    function automatic int sat_cnt(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_50M);
            #2;
        end
    endtask

    task automatic set_period(input int p);
        period = p;
        ph = (p > 0) ? $urandom_range(0, p - 1) : 0;
    endtask

    task automatic wait_valid(input int budget, output int vcyc, output int val,
                              output logic ovf, output int busy_lo, output bit ok);
        ok = 0; vcyc = 0; val = 0; ovf = 1'bx; busy_lo = 0;
        for (int i = 0; i < budget; i++) begin
            step(1);
            if (busy !== 1'b1) busy_lo++;
            if (freq_valid === 1'b1) begin
                vcyc = cyc; val = int'(freq_out); ovf = overflow; ok = 1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; set_period(0);
        step(3);
        total++; if (freq_out !== '0)     begin bad++; $display("FAIL reset_freq_out: got %0d want 0", freq_out); end
        total++; if (freq_valid !== 1'b0) begin bad++; $display("FAIL reset_freq_valid: got %b want 0", freq_valid); end
        total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        total++; if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef PERIOD_MEAS_EN
        total++; if (period_out !== '0 || period_valid !== 1'b0) begin
            bad++; $display("FAIL reset_period: got %0d/%b want 0/0", period_out, period_valid);
        end
`endif
        rst_n = 1'b1;
        step(5);
    endtask

    task automatic test_single();
        int c0, vc, v, bl, exp; logic o; bit ok;
        set_period(10);
        step($urandom_range(5, 30));
        enable = 1'b1; c0 = cyc;
        wait_valid(GATE + 100, vc, v, o, bl, ok);
        enable = 1'b0;
        exp = model(c0 + 1, c0 + GATE);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout: got no freq_valid want one"); end
        total++; if (vc != c0 + GATE + 1) begin bad++; $display("FAIL single_latency: got %0d want %0d", vc - c0, GATE + 1); end
        total++; if (v != sat_cnt(exp)) begin bad++; $display("FAIL single_value: got %0d want %0d", v, sat_cnt(exp)); end
        total++; if (o !== 1'b0) begin bad++; $display("FAIL single_overflow: got %b want 0", o); end
        total++; if (bl != 0) begin bad++; $display("FAIL single_busy: got %0d low cycles want 0", bl); end
        last_exp = sat_cnt(exp); last_ovf = 1'b0;
        step(5);
    endtask

    task automatic test_continuous();
        int c0, bl, bl_sum, v, sum, exp;
        int vcs[4];
        logic o; bit ok;
        set_period(20);
        enable = 1'b1; c0 = cyc; sum = 0; bl_sum = 0;
        for (int g = 0; g < 4; g++) begin
            wait_valid(GATE + 100, vcs[g], v, o, bl, ok);
            bl_sum += bl; sum += v;
            exp = sat_cnt(model(vcs[g] - GATE, vcs[g] - 1));
            total++; if (!ok || v != exp) begin bad++; $display("FAIL cont_value%0d: got %0d want %0d", g, v, exp); end
            if (g == 0) begin
                total++; if (vcs[0] != c0 + GATE + 1) begin bad++; $display("FAIL cont_first: got %0d want %0d", vcs[0] - c0, GATE + 1); end
            end else begin
                total++; if (vcs[g] - vcs[g-1] != GATE) begin bad++; $display("FAIL cont_interval%0d: got %0d want %0d", g, vcs[g] - vcs[g-1], GATE); end
            end
        end
        enable = 1'b0;
        exp = model(c0 + 1, vcs[3] - 1);
        total++; if (sum != exp) begin bad++; $display("FAIL cont_sum: got %0d want %0d", sum, exp); end
        total++; if (bl_sum != 0) begin bad++; $display("FAIL cont_busy: got %0d low cycles want 0", bl_sum); end
        step(5);
    endtask

    task automatic test_saturation();
        int c0, vc, vc2, v, bl, n; logic o; bit ok;
        set_period(2);
        enable = 1'b1; c0 = cyc;
        wait_valid(GATE + 100, vc, v, o, bl, ok);
        set_period(10);
        n = model(c0 + 1, c0 + GATE);
        total++; if (!ok || v != sat_cnt(n)) begin bad++; $display("FAIL sat_value: got %0d want %0d", v, sat_cnt(n)); end
        total++; if (o !== (n > CMAX)) begin bad++; $display("FAIL sat_overflow: got %b want %b", o, n > CMAX); end
        wait_valid(GATE + 100, vc2, v, o, bl, ok);
        enable = 1'b0;
        n = model(vc2 - GATE, vc2 - 1);
        total++; if (!ok || v != sat_cnt(n)) begin bad++; $display("FAIL sat_recover_value: got %0d want %0d", v, sat_cnt(n)); end
        total++; if (o !== (n > CMAX)) begin bad++; $display("FAIL sat_recover_overflow: got %b want %b", o, n > CMAX); end
        last_exp = sat_cnt(n); last_ovf = (n > CMAX);
        step(5);
    endtask

    task automatic test_abort();
        int c0, seen;
        set_period(10);
        enable = 1'b1; c0 = cyc;
        step(500);
        enable = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        step(1);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy_after: got %b want 0", busy); end
        seen = 0;
        for (int i = 0; i < GATE + 200; i++) begin
            step(1);
            if (freq_valid === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_valid: got %0d pulses want 0", seen); end
        total++; if (int'(freq_out) != last_exp || overflow !== last_ovf) begin
            bad++; $display("FAIL abort_hold: got %0d/%b want %0d/%b", freq_out, overflow, last_exp, last_ovf);
        end
    endtask

    task automatic test_reset_midgate();
        int c1, vc, v, bl, exp; logic o; bit ok;
        set_period(10);
        enable = 1'b1;
        step(600);
        #3 rst_n = 1'b0;
        #1;
        total++; if (freq_out !== '0 || overflow !== 1'b0 || busy !== 1'b0 || freq_valid !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: got %0d/%b/%b/%b want 0/0/0/0", freq_out, overflow, busy, freq_valid);
        end
        enable = 1'b0;
        #1 rst_n = 1'b1;
        step(20);
        enable = 1'b1; c1 = cyc;
        wait_valid(GATE + 100, vc, v, o, bl, ok);
        enable = 1'b0;
        exp = sat_cnt(model(c1 + 1, c1 + GATE));
        total++; if (!ok || vc != c1 + GATE + 1) begin bad++; $display("FAIL midreset_latency: got %0d want %0d", vc - c1, GATE + 1); end
        total++; if (v != exp) begin bad++; $display("FAIL midreset_value: got %0d want %0d", v, exp); end
        step(5);
    endtask

    task automatic test_random();
        int c0, vc, v, bl, n; logic o; bit ok;
        for (int k = 0; k < 3; k++) begin
            set_period($urandom_range(2, 60));
            step($urandom_range(3, 40));
            enable = 1'b1; c0 = cyc;
            wait_valid(GATE + 100, vc, v, o, bl, ok);
            enable = 1'b0;
            n = model(c0 + 1, c0 + GATE);
            total++; if (!ok || v != sat_cnt(n) || o !== (n > CMAX)) begin
                bad++; $display("FAIL random%0d: got %0d/%b want %0d/%b (period %0d)", k, v, o, sat_cnt(n), n > CMAX, period);
            end
            step(5);
        end
    endtask

`ifdef PERIOD_MEAS_EN
    task automatic test_period();
        int q0, pv, wrong;
        set_period(0);
        step(5);
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
        q0 = edge_q.size(); pv = 0; wrong = 0;
        set_period(37);
        for (int i = 0; i < 37 * 7; i++) begin
            step(1);
            if (period_valid === 1'b1) begin
                pv++;
                if (period_out !== 32'd37) wrong++;
            end
        end
        set_period(0);
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (period_valid === 1'b1) begin
                pv++;
                if (period_out !== 32'd37) wrong++;
            end
        end
        total++; if (pv != edge_q.size() - q0 - 1) begin bad++; $display("FAIL period_count: got %0d want %0d", pv, edge_q.size() - q0 - 1); end
        total++; if (wrong != 0) begin bad++; $display("FAIL period_value: got %0d wrong values want 0", wrong); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_continuous();
        test_saturation();
        test_abort();
        test_reset_midgate();
        test_random();
`ifdef PERIOD_MEAS_EN
        test_period();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
